// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and types for the pipelined adder.
//   ADDER_WIDTH   default operand/sum width.
//   ADDER_CHUNK   default number of bits added per pipeline stage.
//   adder_stage_t record describing what one stage holds at the default
//                 geometry: valid, carry, partial sum and the operand bits
//                 not yet added. pipelined_adder keeps the same fields per
//                 stage, sized by its own WIDTH/CHUNK, with the operand
//                 remainders trimmed to exactly the bits still to be added.
// Optional feature macro: ADDER_OVERFLOW_EN (adds the signed overflow bit).
package adder_pkg;

  localparam int ADDER_WIDTH = 16;
  localparam int ADDER_CHUNK = 4;

  typedef struct packed {
    logic                   valid;
    logic                   carry;
`ifdef ADDER_OVERFLOW_EN
    logic                   ovf;
`endif
    logic [ADDER_WIDTH-1:0] psum;
    logic [ADDER_WIDTH-1:0] a_rem;
    logic [ADDER_WIDTH-1:0] b_rem;
  } adder_stage_t;

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry adder built from
// full-adder cells.
//   a, b  CHUNK-bit operands
//   cin   carry into bit 0
//   sum   CHUNK-bit sum
//   cout  carry out of bit CHUNK-1
//   cmsb  carry into bit CHUNK-1 (cmsb ^ cout gives signed overflow when
//         this chunk holds the operand MSB)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: sum = a + b + cin over WIDTH bits, added CHUNK bits per
// pipeline stage (N = WIDTH/CHUNK stages, latency N, throughput 1/cycle).
// WIDTH must be a positive multiple of CHUNK.
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready forced low in reset)
//   a, b, cin            operands and carry in
//   out_valid/out_ready  result handshake
//   sum, cout            registered sum and carry out of bit WIDTH-1
//   overflow             registered signed overflow (only when the macro
//                        ADDER_OVERFLOW_EN is defined)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Stage k is ready when it is empty or the stage after it is
// ready (the stage after the last is out_ready), and a ready stage always
// loads whatever its upstream offers, valid or bubble. This lets valid
// entries slide into empty slots while the output is stalled, and lets a
// full pipeline accept and emit in the same cycle. A producer holds its
// data stable while valid && !ready.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int N = WIDTH / CHUNK;

  // rdy[k] is the ready of stage k; rdy[N] is the downstream ready.
  logic [N:0] rdy;

  assign rdy[N]   = out_ready;
  assign in_ready = rdy[0] && !rst;

  for (genvar k = 0; k < N; k++) begin : g_stage
    // Operand bits not yet added when entering this stage.
    localparam int IW = WIDTH - k * CHUNK;

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             vin;
    logic             ci;
    logic [WIDTH-1:0] psum_in;
    logic [WIDTH-1:0] psum_nxt;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             cm;

    // Stage registers: valid, carry out of this chunk, accumulated sum.
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] p_q;

    if (k == 0) begin : g_src
      assign vin     = in_valid;
      assign ci      = cin;
      assign psum_in = '0;
      assign a_in    = a;
      assign b_in    = b;
    end else begin : g_src
      assign vin     = g_stage[k-1].v_q;
      assign ci      = g_stage[k-1].c_q;
      assign psum_in = g_stage[k-1].p_q;
      assign a_in    = g_stage[k-1].g_rem.a_q;
      assign b_in    = g_stage[k-1].g_rem.b_q;
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_in[CHUNK-1:0]),
      .b    (b_in[CHUNK-1:0]),
      .cin  (ci),
      .sum  (s),
      .cout (co),
      .cmsb (cm)
    );

    // Lower chunks pass through; this stage fills in its own chunk.
    always_comb begin
      psum_nxt                    = psum_in;
      psum_nxt[k*CHUNK +: CHUNK]  = s;
    end

    assign rdy[k] = !v_q || rdy[k+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        p_q <= '0;
      end else if (rdy[k]) begin
        v_q <= vin;
        c_q <= co;
        p_q <= psum_nxt;
      end
    end

    // Upper operand chunks still to be added travel with the entry; the
    // last stage has nothing left to carry forward.
    if (k < N - 1) begin : g_rem
      logic [IW-CHUNK-1:0] a_q;
      logic [IW-CHUNK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k]) begin
          a_q <= a_in[IW-1:CHUNK];
          b_q <= b_in[IW-1:CHUNK];
        end
      end
    end

`ifdef ADDER_OVERFLOW_EN
    // Only the top chunk sees the operand MSB, so only it can flag overflow.
    if (k == N - 1) begin : g_ovf
      logic o_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          o_q <= 1'b0;
        end else if (rdy[k]) begin
          o_q <= cm ^ co;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[N-1].v_q;
  assign sum       = g_stage[N-1].p_q;
  assign cout      = g_stage[N-1].c_q;
`ifdef ADDER_OVERFLOW_EN
  assign overflow  = g_stage[N-1].g_ovf.o_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed-vector bench for pipelined_adder at
// WIDTH=16, CHUNK=4. Expected results are hand-computed and queued as
// {overflow, cout, sum}; a negedge monitor pops one per output transfer.
// Compile with +define+ADDER_OVERFLOW_EN to also check the overflow port.
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef ADDER_OVERFLOW_EN
  logic        overflow;
`endif

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          out_cnt = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [17:0] mk(input logic o, input logic c, input logic [15:0] s);
    return {o, c, s};
  endfunction

  // Scoreboard: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("out_has_exp", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_sum", sum, mon_e[15:0]);
        check("out_cout", cout, mon_e[16]);
`ifdef ADDER_OVERFLOW_EN
        check("out_ovf", overflow, mon_e[17]);
`endif
        out_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and returns just after the edge that accepts it,
  // leaving in_valid high so calls can be chained back to back.
  task automatic send(input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input logic [17:0] e);
    int n;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", in_ready, 1);
    if (in_ready) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  logic [15:0] st_a [8] = '{16'h1234, 16'h00FF, 16'hFFFF, 16'h8000,
                            16'hABCD, 16'h0000, 16'hF0F0, 16'h9999};
  logic [15:0] st_b [8] = '{16'h4321, 16'h0F01, 16'hFFFF, 16'h7FFF,
                            16'h1111, 16'h0000, 16'h0F0F, 16'h6667};
  logic        st_c [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] st_s [8] = '{16'h5555, 16'h1001, 16'hFFFF, 16'h0000,
                            16'hBCDE, 16'h0001, 16'hFFFF, 16'h0000};
  logic        st_co[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [15:0] bp_a [5] = '{16'h0001, 16'h1000, 16'hFFF0, 16'h5A5A, 16'h7777};
  logic [15:0] bp_b [5] = '{16'h0002, 16'h2000, 16'h0010, 16'hA5A5, 16'h1111};
  logic        bp_c [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] bp_s [5] = '{16'h0003, 16'h3001, 16'h0000, 16'h0000, 16'h8888};
  logic        bp_co[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic        bub_v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int j;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef ADDER_OVERFLOW_EN
    check("rst_ovf", overflow, 0);
`endif
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    // Full carry chain and latency: result visible after the 4th edge.
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, mk(1'b0, 1'b1, 16'h0000));
    in_valid = 1'b0;
    check("lat_0", out_valid, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("lat_n", out_valid, (i == 3));
    end
    tick();

    // Streaming: 8 back-to-back pairs, one result per cycle.
    for (int i = 0; i < 8; i++)
      send(st_a[i], st_b[i], st_c[i], mk(1'b0, st_co[i], st_s[i]));
    in_valid = 1'b0;
    check("stream_v", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stream_v", out_valid, 1);
    end
    tick();
    check("stream_end", out_valid, 0);
    check("stream_cnt", out_cnt, 9);

    // Backpressure: 6 cycles of in_valid with out_ready low.
    out_ready = 1'b0;
    j = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1;
      a        = bp_a[j];
      b        = bp_b[j];
      cin      = bp_c[j];
      @(negedge clk);
      check("bp_in_ready", in_ready, (cyc < 4));
      if (cyc >= 4) begin
        check("bp_hold_v", out_valid, 1);
        check("bp_hold_sum", sum, 16'h0003);
      end
      if (in_ready) begin
        exp_q.push_back(mk(1'b0, bp_co[j], bp_s[j]));
        j++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("bp_cnt", out_cnt, 13);

    // Bubble collapse: pattern 1,0,1 while stalled.
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = bub_v[cyc];
      a        = (cyc == 0) ? 16'h0F0F : 16'h2222;
      b        = (cyc == 0) ? 16'h0101 : 16'hEEEE;
      cin      = 1'b0;
      @(negedge clk);
      check("bub_in_ready", in_ready, 1);
      if (in_valid && in_ready)
        exp_q.push_back((cyc == 0) ? mk(1'b0, 1'b0, 16'h1010) : mk(1'b0, 1'b1, 16'h1110));
      tick();
    end
    in_valid = 1'b0;
    check("bub_head_v", out_valid, 1);
    check("bub_head_sum", sum, 16'h1010);
    out_ready = 1'b1;
    tick();
    check("bub_packed_v", out_valid, 1);
    check("bub_packed_sum", sum, 16'h1110);
    tick();
    check("bub_end", out_valid, 0);
    check("bub_cnt", out_cnt, 15);

    // Signed overflow corner cases.
    send(16'h7FFF, 16'h0001, 1'b0, mk(1'b1, 1'b0, 16'h8000));
    send(16'h8000, 16'h8000, 1'b0, mk(1'b1, 1'b1, 16'h0000));
    in_valid = 1'b0;
    repeat (6) tick();
    check("ovf_cnt", out_cnt, 17);

    // Reset with three operations in flight.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, mk(1'b0, 1'b0, 16'h3333));
    send(16'h4444, 16'h1111, 1'b0, mk(1'b0, 1'b0, 16'h5555));
    send(16'h0F00, 16'h00F0, 1'b1, mk(1'b0, 1'b0, 16'h0FF1));
    in_valid = 1'b0;
    tick();
    check("mid_head_v", out_valid, 1);
    check("mid_head_sum", sum, 16'h3333);
    rst = 1'b1;
    tick();
    check("mid_rst_v", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mid_no_stale", out_valid, 0);
    end

    check("final_q_empty", exp_q.size(), 0);
    check("final_cnt", out_cnt, 17);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
